// File: rtl/llc_way_select_pkg.sv
// llc_way_select_pkg
//   Shared LLC constants and types for the way-select block: set geometry,
//   tag/state/way types, the INVALID coherence-state encoding and the
//   one-hot response-kind record.
//   No ports (package).

package llc_way_select_pkg;

  localparam int LLC_WAYS    = 16;
  localparam int LLC_WAY_W   = $clog2(LLC_WAYS);
  localparam int LLC_TAG_W   = 20;
  localparam int LLC_STATE_W = 3;

  typedef logic [LLC_WAY_W-1:0]   llc_way_t;
  typedef logic [LLC_TAG_W-1:0]   llc_tag_t;
  typedef logic [LLC_STATE_W-1:0] llc_state_t;

  localparam llc_state_t LLC_STATE_INVALID = '0;

  // Exactly one field is set while a response is presented.
  typedef struct packed {
    logic hit;
    logic empty;
    logic evict;
    logic fail;
  } llc_rsp_kind_t;

endpackage

// File: rtl/llc_way_select_prio_enc.sv
// llc_way_prio_enc
//   Lowest-index priority encoder used to pick the first hit way and the
//   first INVALID way of a set.
//   Ports:
//     vec    in   N   one bit per way
//     found  out  1   any bit of vec set
//     idx    out  W   index of the lowest set bit (0 when none set)

module llc_way_prio_enc
  import llc_way_select_pkg::*;
#(
  parameter int N = LLC_WAYS,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top down so the last assignment wins with the lowest index.
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/llc_way_select.sv
// llc_way_select
//   Resolves a lookup tag against the per-set way buffers to a hit way, the
//   first empty way, or a round-robin victim that skips locked ways. While
//   scanning for a victim it pulses incr_evict_way_buf once per skipped way so
//   the external evict pointer lands on the chosen way.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/ready/tag      lookup request (accepted only in IDLE)
//     tags_buf, states_buf     way i at [i*TAG_W +: TAG_W] / [i*STATE_W +: STATE_W]
//     lock_mask                1 = way not evictable, sampled live while scanning
//     evict_way_buf            current round-robin evict pointer
//     incr_evict_way_buf       one-cycle pulse: advance evict pointer by 1
//     rsp_valid/ready          result handshake, result held until accepted
//     rsp_hit/empty/evict/fail one-hot result kind
//     rsp_way                  selected way
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; latch req_tag on handshake
// CMP   | compare tag against all ways; resolve hit or empty way
// SCAN  | walk the evict pointer one way per cycle past locked ways
// RSP   | present result until rsp_ready

module llc_way_select
  import llc_way_select_pkg::*;
#(
  parameter int WAYS    = LLC_WAYS,
  parameter int WAY_W   = $clog2(WAYS),
  parameter int TAG_W   = LLC_TAG_W,
  parameter int STATE_W = LLC_STATE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [WAYS*TAG_W-1:0] tags_buf,
  input  logic [WAYS*STATE_W-1:0] states_buf,
  input  logic [WAYS-1:0]       lock_mask,
  input  logic [WAY_W-1:0]      evict_way_buf,
  output logic                  incr_evict_way_buf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_empty,
  output logic                  rsp_evict,
  output logic                  rsp_fail,
  output logic [WAY_W-1:0]      rsp_way
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_SCAN,
    S_RSP
  } state_t;

  localparam logic [STATE_W-1:0] STATE_INV = STATE_W'(LLC_STATE_INVALID);
  localparam logic [WAY_W-1:0]   LAST_CNT  = WAY_W'(WAYS - 1);

  state_t             state_q, state_nxt;
  logic [TAG_W-1:0]   tag_q, tag_nxt;
  logic [WAY_W-1:0]   ptr_q, ptr_nxt;
  logic [WAY_W-1:0]   cnt_q, cnt_nxt;
  llc_rsp_kind_t      kind_q, kind_nxt;
  logic [WAY_W-1:0]   way_q, way_nxt;
  logic               incr_c;

  logic [WAYS-1:0]    hit_vec;
  logic [WAYS-1:0]    inv_vec;
  logic               hit_found, inv_found;
  logic [WAY_W-1:0]   hit_idx, inv_idx;

  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    for (int i = 0; i < WAYS; i++) begin
      inv_vec[i] = (states_buf[i*STATE_W +: STATE_W] == STATE_INV);
      hit_vec[i] = !inv_vec[i] && (tags_buf[i*TAG_W +: TAG_W] == tag_q);
    end
  end

  llc_way_prio_enc #(.N(WAYS), .W(WAY_W)) u_hit_enc (
    .vec   (hit_vec),
    .found (hit_found),
    .idx   (hit_idx)
  );

  llc_way_prio_enc #(.N(WAYS), .W(WAY_W)) u_inv_enc (
    .vec   (inv_vec),
    .found (inv_found),
    .idx   (inv_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      kind_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tag_q   <= tag_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
      kind_q  <= kind_nxt;
      way_q   <= way_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tag_nxt   = tag_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    kind_nxt  = kind_q;
    way_nxt   = way_q;
    incr_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tag_nxt   = req_tag;
          state_nxt = S_CMP;
        end
      end

      S_CMP: begin
        if (hit_found) begin
          kind_nxt     = '0;
          kind_nxt.hit = 1'b1;
          way_nxt      = hit_idx;
          state_nxt    = S_RSP;
        end else if (inv_found) begin
          kind_nxt       = '0;
          kind_nxt.empty = 1'b1;
          way_nxt        = inv_idx;
          state_nxt      = S_RSP;
        end else begin
          ptr_nxt   = evict_way_buf;
          cnt_nxt   = '0;
          state_nxt = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!lock_mask[ptr_q]) begin
          kind_nxt       = '0;
          kind_nxt.evict = 1'b1;
          way_nxt        = ptr_q;
          state_nxt      = S_RSP;
        end else begin
          // Each skipped way advances the external pointer, keeping it in
          // lockstep with ptr_q.
          incr_c  = 1'b1;
          ptr_nxt = ptr_q + 1'b1;
          cnt_nxt = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // All ways locked: pointer has wrapped back to where it started.
            kind_nxt      = '0;
            kind_nxt.fail = 1'b1;
            way_nxt       = ptr_q + 1'b1;
            state_nxt     = S_RSP;
          end
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          kind_nxt  = '0;
          way_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready          = (state_q == S_IDLE);
  assign rsp_valid          = (state_q == S_RSP);
  // Masked by rst so an aborted scan cannot leak a pointer advance.
  assign incr_evict_way_buf = incr_c & ~rst;
  assign rsp_hit            = kind_q.hit;
  assign rsp_empty          = kind_q.empty;
  assign rsp_evict          = kind_q.evict;
  assign rsp_fail           = kind_q.fail;
  assign rsp_way            = way_q;

endmodule

// File: tb/tb_llc_way_select.sv
module tb_llc_way_select;

  localparam int WAYS    = 16;
  localparam int WAY_W   = 4;
  localparam int TAG_W   = 20;
  localparam int STATE_W = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      req_valid;
  logic                      req_ready;
  logic [TAG_W-1:0]          req_tag;
  logic [WAYS*TAG_W-1:0]     tags_buf;
  logic [WAYS*STATE_W-1:0]   states_buf;
  logic [WAYS-1:0]           lock_mask;
  logic [WAY_W-1:0]          evict_way_buf;
  logic                      incr_evict_way_buf;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_hit, rsp_empty, rsp_evict, rsp_fail;
  logic [WAY_W-1:0]          rsp_way;

  always #5 clk = ~clk;

  llc_way_select dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_tag            (req_tag),
    .tags_buf           (tags_buf),
    .states_buf         (states_buf),
    .lock_mask          (lock_mask),
    .evict_way_buf      (evict_way_buf),
    .incr_evict_way_buf (incr_evict_way_buf),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_hit            (rsp_hit),
    .rsp_empty          (rsp_empty),
    .rsp_evict          (rsp_evict),
    .rsp_fail           (rsp_fail),
    .rsp_way            (rsp_way)
  );

  // kind encoding: {hit, empty, evict, fail}
  localparam logic [3:0] K_HIT = 4'b1000, K_EMPTY = 4'b0100, K_EVICT = 4'b0010, K_FAIL = 4'b0001;

  typedef struct {
    string                   name;
    logic [WAYS*TAG_W-1:0]   tags;
    logic [WAYS*STATE_W-1:0] states;
    logic [WAYS-1:0]         lock;
    logic [WAY_W-1:0]        ptr;
    logic [TAG_W-1:0]        tag;
    logic [3:0]              exp_kind;
    logic [WAY_W-1:0]        exp_way;
    int                      exp_lat;
    int                      exp_pulses;
  } vec_t;

  typedef struct {
    string            name;
    logic [3:0]       kind;
    logic [WAY_W-1:0] way;
    int               lat;
    int               pulses;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // All ways valid, distinct tags 0x100+i, non-zero states.
  function automatic vec_t mk(input string n, input logic [TAG_W-1:0] tag,
                              input logic [WAYS-1:0] lock, input logic [WAY_W-1:0] ptr,
                              input logic [3:0] kind, input logic [WAY_W-1:0] way,
                              input int lat, input int pulses);
    vec_t v;
    v.name = n; v.tag = tag; v.lock = lock; v.ptr = ptr;
    v.exp_kind = kind; v.exp_way = way; v.exp_lat = lat; v.exp_pulses = pulses;
    for (int i = 0; i < WAYS; i++) begin
      v.tags[i*TAG_W +: TAG_W]       = TAG_W'(32'h100 + i);
      v.states[i*STATE_W +: STATE_W] = STATE_W'((i % 7) + 1);
    end
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   lat, pulses;
    bit   done;
    exp_t e;
    tags_buf = v.tags; states_buf = v.states; lock_mask = v.lock;
    evict_way_buf = v.ptr; req_tag = v.tag; rsp_ready = 1'b1; req_valid = 1'b1;
    chk({v.name, "/req_ready"}, 32'(req_ready), 32'd1);
    step();
    sb.push_back('{v.name, v.exp_kind, v.exp_way, v.exp_lat, v.exp_pulses});
    req_valid = 1'b0;
    req_tag   = ~v.tag;
    lat = 1; pulses = 0; done = 0;
    while (!done && lat <= 40) begin
      if (rsp_valid) done = 1;
      else begin
        if (incr_evict_way_buf) begin
          pulses++;
          evict_way_buf = evict_way_buf + 1'b1;
        end
        step();
        lat++;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s/timeout: rsp_valid not seen within 40 cycles", v.name);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({e.name, "/kind"},   32'({rsp_hit, rsp_empty, rsp_evict, rsp_fail}), 32'(e.kind));
      chk({e.name, "/way"},    32'(rsp_way), 32'(e.way));
      chk({e.name, "/lat"},    32'(lat), 32'(e.lat));
      chk({e.name, "/pulses"}, 32'(pulses), 32'(e.pulses));
      if (e.kind == K_EVICT || e.kind == K_FAIL)
        chk({e.name, "/ptr_sync"}, 32'(evict_way_buf), 32'(e.way));
      step();
      chk({e.name, "/rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
      chk({e.name, "/idle_ready"},    32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;

    vecs[0] = mk("hit5", 20'h01234, 16'h0000, 4'd0, K_HIT, 4'd5, 2, 0);
    vecs[0].tags[5*TAG_W +: TAG_W] = 20'h01234;
    vecs[0].states[5*STATE_W +: STATE_W] = 3'd3;
    vecs[1] = mk("hit_dup", 20'hABCDE, 16'h0000, 4'd0, K_HIT, 4'd3, 2, 0);
    vecs[1].tags[3*TAG_W +: TAG_W]  = 20'hABCDE;
    vecs[1].tags[11*TAG_W +: TAG_W] = 20'hABCDE;
    vecs[2] = mk("hit15", 20'hFFFFF, 16'hFFFF, 4'd2, K_HIT, 4'd15, 2, 0);
    vecs[2].tags[15*TAG_W +: TAG_W] = 20'hFFFFF;
    vecs[3] = mk("inv_tag_match", 20'h00777, 16'h0000, 4'd0, K_EMPTY, 4'd4, 2, 0);
    vecs[3].tags[4*TAG_W +: TAG_W] = 20'h00777;
    vecs[3].states[4*STATE_W +: STATE_W] = 3'd0;
    vecs[4] = mk("empty2_9", 20'h55555, 16'h0000, 4'd0, K_EMPTY, 4'd2, 2, 0);
    vecs[4].states[2*STATE_W +: STATE_W] = 3'd0;
    vecs[4].states[9*STATE_W +: STATE_W] = 3'd0;
    vecs[5] = mk("evict_wrap", 20'h55555, 16'hC000, 4'd14, K_EVICT, 4'd0, 5, 2);
    vecs[6] = mk("evict_noskip", 20'h55555, 16'h0001, 4'd3, K_EVICT, 4'd3, 3, 0);
    vecs[7] = mk("fail_all", 20'h55555, 16'hFFFF, 4'd7, K_FAIL, 4'd7, 18, 16);
    vecs[8] = mk("evict_last", 20'h55555, 16'h7FFF, 4'd0, K_EVICT, 4'd15, 18, 15);

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_tag = '0;
    tags_buf = '0; states_buf = '0; lock_mask = '0; evict_way_buf = '0;
    repeat (3) step();
    chk("reset/req_ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/flags", 32'({rsp_hit, rsp_empty, rsp_evict, rsp_fail}), 32'd0);
    chk("reset/way", 32'(rsp_way), 32'd0);
    chk("reset/incr", 32'(incr_evict_way_buf), 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset in the middle of a full-lock scan.
    v = vecs[7];
    tags_buf = v.tags; states_buf = v.states; lock_mask = 16'hFFFF;
    evict_way_buf = 4'd7; req_tag = v.tag; rsp_ready = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("midrst/in_scan_incr", 32'(incr_evict_way_buf), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst/incr_masked", 32'(incr_evict_way_buf), 32'd0);
    step();
    chk("midrst/incr_rst2", 32'(incr_evict_way_buf), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst/req_ready", 32'(req_ready), 32'd1);
    chk("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (incr_evict_way_buf) n++;
      step();
    end
    chk("midrst/no_pulses", 32'(n), 32'd0);

    // Backpressure: result held, new request ignored.
    v = vecs[0];
    tags_buf = v.tags; states_buf = v.states; lock_mask = '0;
    evict_way_buf = '0; req_tag = v.tag; rsp_ready = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    chk("bp/rsp_valid_seen", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_tag = 20'h00105;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp/hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp/hold_kind", 32'({rsp_hit, rsp_empty, rsp_evict, rsp_fail}), 32'(K_HIT));
      chk("bp/hold_way", 32'(rsp_way), 32'd5);
      chk("bp/req_ready_low", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("bp/rsp_valid_clr", 32'(rsp_valid), 32'd0);
    chk("bp/idle_ready", 32'(req_ready), 32'd1);
    chk("bp/flags_clr", 32'({rsp_hit, rsp_empty, rsp_evict, rsp_fail}), 32'd0);
    step();
    chk("bp/stay_idle", 32'(req_ready), 32'd1);

    // Back-to-back lookup straight after the backpressured one.
    run_vec(vecs[4]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
